instr_fetch_ctrl: RTL
=====================

Name: instr_fetch_ctrl

Overview:
Sequences the combinational instruction memory. It owns the fetch program counter, drives the memory address, and buffers fetched words plus their PCs in a small prefetch FIFO. Decode drains the FIFO through a valid/ready handshake. A branch/jump redirect flushes the FIFO and restarts fetching; the block sits between Instr_Memory and the decode stage.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
RESET_PC, 32'h0000_0000, fetch PC after reset; word-aligned.
MEM_WORDS, 32, instruction memory size in words; the fetch limit is MEM_WORDS*4 bytes.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  asynchronous active-low reset.
fetch_en_i  in  1  permits fetching this cycle.
mem_addr_o  out  32  byte address to instruction memory; equals fetch_pc, combinational from the register.
mem_instr_i  in  32  instruction word returned combinationally for mem_addr_o.
redirect_i  in  1  one-cycle pulse from branch/jump resolution.
redirect_pc_i  in  32  new fetch target, sampled when redirect_i=1.
instr_valid_o  out  1  FIFO head is valid.
instr_ready_i  in  1  decode accepts the head.
instr_o  out  32  head instruction; 0 when instr_valid_o=0.
instr_pc_o  out  32  PC of the head instruction; 0 when instr_valid_o=0.
done_o  out  1  fetch_pc at or beyond the limit and FIFO empty.
fault_o  out  1  sticky misaligned-redirect flag.

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, count=0, wr_ptr=rd_ptr=0, fault=0. All outputs: instr_valid_o=0, instr_o=0, instr_pc_o=0, done_o=0 (if RESET_PC < limit), fault_o=0, mem_addr_o=RESET_PC.
- Definitions: limit = MEM_WORDS*4. pop = instr_valid_o & instr_ready_i. at_end = (fetch_pc >= limit).
- push = fetch_en_i & !redirect_i & !fault & !at_end & (count<DEPTH | pop).
- On push: write {fetch_pc, mem_instr_i} at wr_ptr, then fetch_pc += 4.
- Latency: a word fetched at edge N is visible on instr_o after edge N, so it is poppable in cycle N+1. Best-case throughput is 1 instruction/cycle.
- Full FIFO with a simultaneous pop: push is allowed and count is unchanged.
- Empty FIFO: the pop path is ignored because valid=0. There is no bypass; a word is never presented in the cycle it is fetched.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither. Pointers wrap modulo DEPTH. count is clog2(DEPTH+1) bits wide.
- Redirect priority (redirect_i=1), all in one cycle:
  - count, wr_ptr and rd_ptr are cleared and no push occurs.
  - A head accepted in the same cycle (pop=1) counts as consumed by decode; everything else is discarded.
  - If redirect_pc_i[1:0]==0: fetch_pc <= redirect_pc_i.
  - If redirect_pc_i[1:0]!=0: fault <= 1 and fetch_pc is unchanged.
- Fault: sticky until reset. It blocks all pushes. Pops drain nothing because the FIFO was flushed. Later redirects are ignored.
- At end: when fetch_pc reaches the limit, fetching pauses and mem_addr_o keeps showing fetch_pc (the memory output is ignored). A valid redirect resumes fetching. A redirect to an address >= limit is legal and pauses immediately.
- done_o = at_end & (count==0) & !fault, registered-state derived.
- fetch_en_i=0: no push. FIFO pops continue, and redirects are still honoured.
- fetch_pc wraps modulo 2^32. This is unreachable in practice because at_end stops increments.
- instr_valid_o = (count!=0). Valid is never withdrawn without a pop, except by redirect flush or reset.

Decomposition:
- Shared package (cpu_pkg): constants IMEM_WORDS=32 and RESET_PC; typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr}.
- Sub-module fetch_fifo: a synchronous DEPTH-entry FIFO with push, pop and flush inputs, and count, full and empty outputs. The controller holds the PC, the push/pop policy and the fault/done logic.

Test Plan:
1. Reset then fetch_en_i=1 with ready=1 (DEPTH=4, memory words = index*16) -> cycle 1 presents pc=0/instr=0x0, cycle 2 presents pc=4/instr=0x10. The stream stays contiguous at one instruction per cycle through pc=0x7C, then done_o=1.
2. ready=0 for 8 cycles -> count saturates at 4, and mem_addr_o holds 0x10. Raising ready gives an in-order pc 0,4,8,C, then 0x10 follows with no gap (push during pop while full).
3. Redirect to 0x40 while FIFO holds pc 8..0x14 and ready=1 -> the pc=8 head is consumed. Next cycle valid=0, then the head becomes pc=0x40/instr=0x40*4.
4. Redirect to 0x22 (misaligned) -> fault_o=1 next cycle and the FIFO is empty. A later redirect to 0x0 is ignored, and valid stays 0 until rst_i low.
5. Redirect to 0x7C -> one instruction (pc=0x7C) is delivered, then done_o=1. Redirect to 0x0 clears done_o and fetching resumes.
6. Assert rst_i low mid-stream with count=3 -> outputs clear immediately (asynchronously). After release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the prefetch entry layout used by the fetch path.
package cpu_pkg;

   localparam int          IMEM_WORDS = 32;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of {pc, instr}, combinational head read, flush clears pointers.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     wdata,
   output fetch_entry_t     rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   fetch_entry_t     mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;

   // Storage is not reset; only the pointers and count define what is live.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_reg[wr_ptr_reg] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign rdata = mem_reg[rd_ptr_reg];
   assign count = count_reg;
   assign full  = (count_reg == CNT_W'(DEPTH));
   assign empty = (count_reg == '0);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: owns the fetch PC, feeds the prefetch FIFO from instruction memory,
// and handles redirects, the misaligned-redirect fault and the end-of-memory pause.
module instr_fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
   parameter int          MEM_WORDS = IMEM_WORDS
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fetch_en_i,
   output logic [31:0] mem_addr_o,
   input  logic [31:0] mem_instr_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        done_o,
   output logic        fault_o
);

   localparam int          CNT_W = $clog2(DEPTH + 1);
   localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);

   logic [31:0]      fetch_pc_reg;
   logic [31:0]      fetch_pc_next;
   logic             fault_reg;
   logic             fault_next;
   logic             at_end;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   fetch_entry_t     wr_entry;
   fetch_entry_t     head;

   assign at_end = (fetch_pc_reg >= LIMIT);
   assign pop    = !fifo_empty && instr_ready_i;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign push   = fetch_en_i && !redirect_i && !fault_reg && !at_end && (!fifo_full || pop);

   always_comb begin
      fetch_pc_next = fetch_pc_reg;
      fault_next    = fault_reg;
      if (redirect_i) begin
         if (!fault_reg) begin
            if (redirect_pc_i[1:0] == 2'b00) begin
               fetch_pc_next = redirect_pc_i;
            end else begin
               fault_next = 1'b1;
            end
         end
      end else if (push) begin
         fetch_pc_next = fetch_pc_reg + 32'd4;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         fetch_pc_reg <= RESET_PC;
         fault_reg    <= 1'b0;
      end else begin
         fetch_pc_reg <= fetch_pc_next;
         fault_reg    <= fault_next;
      end
   end

   assign wr_entry = '{pc: fetch_pc_reg, instr: mem_instr_i};

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_i),
      .push  (push),
      .pop   (pop),
      .flush (redirect_i),
      .wdata (wr_entry),
      .rdata (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign mem_addr_o    = fetch_pc_reg;
   assign instr_valid_o = !fifo_empty;
   assign instr_o       = fifo_empty ? 32'd0 : head.instr;
   assign instr_pc_o    = fifo_empty ? 32'd0 : head.pc;
   assign done_o        = at_end && (fifo_count == '0) && !fault_reg;
   assign fault_o       = fault_reg;

endmodule
